muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit executing the RV64M instructions the decoder flags as `is_muldiv` (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms). It sits beside the ALU in the execute stage. It accepts one operation through a valid/ready handshake, sequences a shift-add multiplier or a restoring divider over multiple cycles, and returns a one-cycle result pulse. The pipeline stalls execute while an operation is outstanding.

## Interface
- `XLEN`: default `eei::XLEN` (64); operand and result width.
- `clk` in, 1: clock.
- `rst` in, 1: synchronous, active-low reset.
- `valid` in, 1: operation request.
- `ready` out, 1: unit idle and able to accept.
- `funct3` in, 3: the decoder's `ctrl.funct3`; selects the operation.
- `is_op32` in, 1: the decoder's `ctrl.is_op32`; selects the W form.
- `op1` in, XLEN: rs1 value.
- `op2` in, XLEN: rs2 value.
- `flush` in, 1: squash the in-flight or offered operation.
- `rvalid` out, 1: result valid, one-cycle pulse.
- `result` out, XLEN: result value, held until the next accept.

## Operation
- `funct3` encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - With `is_op32` set, only 000/100/101/110/111 are legal; other codes are undefined and need not be checked.
- Accept condition: `valid && ready && !flush`. At accept, latch funct3, is_op32, operand magnitudes and result sign.
- W forms: operands use bits [31:0], sign- or zero-extended per op. The result is bits [31:0] of the 32-bit result, sign-extended to XLEN, for both signed and unsigned W ops.
- Signed handling: iterate on absolute values.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Multiply:
  - 2·XLEN-bit accumulator, one multiplier bit per cycle.
  - MUL returns the low half; MULH* return the high half.
- Divide: restoring, one quotient bit per cycle.
- Special cases bypass iteration and go straight to FINISH:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative ÷ −1): quotient = dividend; remainder = 0.
  - W forms apply the 32-bit equivalents of both rules.
- Iteration count ITER = XLEN for 64-bit ops and 32 for W ops. The count is held in a 7-bit counter.
- State machine:
  - IDLE → MUL or DIV on accept; IDLE → FINISH on accept of a special case.
  - MUL/DIV → FINISH when the counter reaches ITER−1.
  - FINISH → IDLE unconditionally.
- `ready` = (state == IDLE) && rst high.

## Timing
- Reset state (rst low at a clock edge): state IDLE, `rvalid` 0, `result` 0, counter 0. `ready` reads 0 while rst is low.
- Cycle 0 is the accept cycle. MUL/DIV occupy cycles 1..ITER. `rvalid`=1 in cycle ITER+1 (FINISH). `ready`=1 again in cycle ITER+2.
  - 64-bit op: 66 cycles from accept to the next possible accept.
  - W op: 34 cycles.
  - Special case: `rvalid` in cycle 1.
- `result` registers on entry to FINISH and is stable until the next accept.
- `flush` while in MUL/DIV: state returns to IDLE next cycle, no `rvalid`, `result` unchanged.
- `flush` while in FINISH: `rvalid` still pulses this cycle; the consumer discards it.
- `flush` in IDLE together with `valid`: not accepted.
- `valid` asserted while busy: ignored; the requester holds it until `ready`.
- Reset mid-operation: returns to IDLE on the same edge; no `rvalid`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - Multiplies use a single-cycle XLEN×XLEN product; the MUL state lasts exactly one cycle. MUL `rvalid` in cycle 2 for both 64-bit and W forms.
  - Divides are unchanged.
- `MULDIV_FAST_MUL_EN` undefined: iterative shift-add as above.

## Structure
- Shared package `corectrl`:
  - `MulDivState` enum: IDLE, MUL, DIV, FINISH.
  - funct3 localparams: `MD_MUL` … `MD_REMU`.
- Sub-module `muldiv_divider`: restoring-divider datapath. It holds the remainder/quotient registers and exposes start, step, quotient and remainder. `muldiv_unit` owns the FSM, counter, sign fix-up and the multiplier.

## Test plan
- MUL op1=7, op2=−3 (64-bit) → `rvalid` in cycle 65 after accept, `result`=0xFFFF_FFFF_FFFF_FFEB; `ready` low cycles 1–65.
- MULHU op1=op2=0xFFFF_FFFF_FFFF_FFFF → `result`=0xFFFF_FFFF_FFFF_FFFE; MULHSU op1=−1, op2=2 → `result`=0xFFFF_FFFF_FFFF_FFFF.
- DIV op1=−7, op2=2 → `result`=−3. REM with the same operands → −1. DIVUW op1=0x1_8000_0000, op2=1 → `result`=0xFFFF_FFFF_8000_0000, `rvalid` in cycle 33.
- DIV op1=5, op2=0 → `rvalid` in cycle 1, `result`=all ones. REM 5÷0 → 5. DIV 0x8000_0000_0000_0000 ÷ −1 → 0x8000_0000_0000_0000. REM of the same → 0.
- `flush` in cycle 10 of a DIV → no `rvalid` within the next 70 cycles, `ready`=1 in cycle 11. A new MUL accepted in cycle 11 completes correctly.
- `rst` low in cycle 20 of a MUL → `rvalid`=0, `result`=0 next cycle. Repeat with `MULDIV_FAST_MUL_EN` defined and check MUL `rvalid` in cycle 2.

Source files
------------

// File: rtl/corectrl_pkg.sv
// rtl/corectrl_pkg.sv - core control types: mul/div FSM states and M-extension funct3 codes
package corectrl;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} MulDivState;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
endpackage

// File: rtl/eei_pkg.sv
// rtl/eei_pkg.sv - execution environment parameters shared by the core
package eei;
  localparam int XLEN = 64;
endpackage

// File: rtl/muldiv_divider.sv
// rtl/muldiv_divider.sv - restoring divider datapath on unsigned magnitudes, one quotient bit per step
module muldiv_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            is_op32,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsor_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;

  // quotient/remainder show the values after the step taken this cycle,
  // so the caller can capture the final result on its last step
  always_comb begin
    shifted   = {rem_q, quot_q[XLEN-1]};
    diff      = shifted - {1'b0, dsor_q};
    fits      = ~diff[XLEN];
    quotient  = {quot_q[XLEN-2:0], fits};
    remainder = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsor_q <= '0;
    end else if (start) begin
      // W dividends start at the top so 32 steps consume all of them
      quot_q <= is_op32 ? (dividend << 32) : dividend;
      rem_q  <= '0;
      dsor_q <= divisor;
    end else if (step) begin
      quot_q <= quotient;
      rem_q  <= remainder;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV64M multiply/divide unit; define MULDIV_FAST_MUL_EN for a single-cycle multiplier
module muldiv_unit
  import corectrl::*;
#(
  parameter int XLEN = eei::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  output logic            ready,
  input  logic [2:0]      funct3,
  input  logic            is_op32,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            rvalid,
  output logic [XLEN-1:0] result
);
  localparam int W2 = 2 * XLEN;

  MulDivState      state;
  logic [6:0]      count;
  logic [2:0]      op_f3;
  logic            op_w;
  logic            neg_q;
  logic            neg_r;
  logic [W2-1:0]   mcand;
  logic [W2-1:0]   acc;
  logic [XLEN-1:0] mplier;

  logic            sgn1, sgn2, s1, s2;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_val;
  logic            accept, is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  logic [6:0]      iter_last;
  logic [W2-1:0]   acc_next, mul_prod, mul_full;
  logic            mul_done;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] quotient, remainder, div_q, div_r, div_res;

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (funct3)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      MD_MULHSU: sgn1 = 1'b1;
      MD_MULHU, MD_DIVU, MD_REMU: ;
      default: ;
    endcase
  end

  assign ext1    = is_op32 ? {{(XLEN-32){sgn1 & op1[31]}}, op1[31:0]} : op1;
  assign ext2    = is_op32 ? {{(XLEN-32){sgn2 & op2[31]}}, op2[31:0]} : op2;
  assign s1      = sgn1 & ext1[XLEN-1];
  assign s2      = sgn2 & ext2[XLEN-1];
  assign mag1    = s1 ? -ext1 : ext1;
  assign mag2    = s2 ? -ext2 : ext2;
  assign min_val = is_op32 ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};

  assign ready    = (state == IDLE) && rst;
  assign accept   = valid && ready && !flush;
  assign is_div   = funct3[2];
  assign div_zero = is_div && (ext2 == '0);
  assign div_ovf  = is_div && sgn1 && (ext1 == min_val) && (ext2 == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    if (funct3[1]) special_res = div_zero ? wfix(is_op32, op1) : '0;
    else           special_res = div_zero ? '1 : ext1;
  end

  assign iter_last = op_w ? 7'd31 : 7'(XLEN - 1);
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

`ifdef MULDIV_FAST_MUL_EN
  assign mul_prod = mcand * {{XLEN{1'b0}}, mplier};
  assign mul_done = 1'b1;
`else
  assign mul_prod = acc_next;
  assign mul_done = (count == iter_last);
`endif

  assign mul_full = neg_q ? -mul_prod : mul_prod;

  always_comb begin
    if (op_w)                 mul_res = wfix(1'b1, mul_full[XLEN-1:0]);
    else if (op_f3 == MD_MUL) mul_res = mul_full[XLEN-1:0];
    else                      mul_res = mul_full[W2-1:XLEN];
  end

  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .step      ((state == DIV) && !flush),
    .is_op32   (is_op32),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign div_q   = neg_q ? -quotient : quotient;
  assign div_r   = neg_r ? -remainder : remainder;
  assign div_res = wfix(op_w, op_f3[1] ? div_r : div_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      rvalid <= 1'b0;
      result <= '0;
      count  <= '0;
      op_f3  <= '0;
      op_w   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_f3  <= funct3;
          op_w   <= is_op32;
          neg_q  <= s1 ^ s2;
          neg_r  <= s1;
          count  <= '0;
          mcand  <= {{XLEN{1'b0}}, mag1};
          mplier <= mag2;
          acc    <= '0;
          if (special) begin
            state  <= FINISH;
            rvalid <= 1'b1;
            result <= special_res;
          end else begin
            state <= is_div ? DIV : MUL;
          end
        end
        MUL: if (flush) begin
          state <= IDLE;
        end else begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 7'd1;
          if (mul_done) begin
            state  <= FINISH;
            rvalid <= 1'b1;
            result <= mul_res;
          end
        end
        DIV: if (flush) begin
          state <= IDLE;
        end else begin
          count <= count + 7'd1;
          if (count == iter_last) begin
            state  <= FINISH;
            rvalid <= 1'b1;
            result <= div_res;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit: results, latency, flush and reset
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, valid, is_op32, flush;
  logic [2:0]  funct3;
  logic [63:0] op1, op2, result;
  logic        ready, rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
  } vec_t;

  logic [63:0] sb_q[$];

  muldiv_unit #(.XLEN(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .ready   (ready),
    .funct3  (funct3),
    .is_op32 (is_op32),
    .op1     (op1),
    .op2     (op2),
    .flush   (flush),
    .rvalid  (rvalid),
    .result  (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    logic [31:0]  a32, b32, r32;
    longint       la, lb;
    int           ia, ib;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    la = a;
    lb = b;
    a32 = a[31:0];
    b32 = b[31:0];
    ia = a32;
    ib = b32;
    r32 = '0;
    if (!w) begin
      case (f3)
        3'd0: return a * b;
        3'd1: begin p = sa * sb; return p[127:64]; end
        3'd2: begin p = sa * ub; return p[127:64]; end
        3'd3: begin p = ua * ub; return p[127:64]; end
        3'd4: if (b == 0) return '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) return a; else return la / lb;
        3'd5: if (b == 0) return '1; else return a / b;
        3'd6: if (b == 0) return a; else if (a == 64'h8000_0000_0000_0000 && b == '1) return 0; else return la % lb;
        default: if (b == 0) return a; else return a % b;
      endcase
    end
    case (f3)
      3'd0: r32 = a32 * b32;
      3'd4: if (b32 == 0) r32 = '1; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32; else r32 = ia / ib;
      3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
      3'd6: if (b32 == 0) r32 = a32; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 0; else r32 = ia % ib;
      3'd7: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
      default: r32 = 'x;
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  function automatic int lat_of(input vec_t t);
    logic zero, ovf;
    if (t.f3[2]) begin
      zero = t.w ? (t.b[31:0] == 0) : (t.b == 0);
      ovf  = !t.f3[0] && (t.w ? (t.a[31:0] == 32'h8000_0000 && t.b[31:0] == '1)
                              : (t.a == 64'h8000_0000_0000_0000 && t.b == '1));
      if (zero || ovf) return 1;
      return t.w ? 33 : 65;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 2;
`else
    return t.w ? 33 : 65;
`endif
  endfunction

  task automatic issue(input vec_t t);
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    valid = 1'b1; funct3 = t.f3; is_op32 = t.w; op1 = t.a; op2 = t.b;
    sb_q.push_back(t.e);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_result(output logic [63:0] got, output int lat, output logic rdy_busy);
    got = 'x; lat = -1; rdy_busy = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (ready === 1'b1) rdy_busy = 1'b1;
      if (rvalid === 1'b1) begin
        got = result;
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (ready !== 1'b0)  begin n_bad++; $display("FAIL reset_ready got %b exp 0", ready); end
    n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
    n_cmp++; if (result !== 64'd0) begin n_bad++; $display("FAIL reset_result got %h exp 0", result); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1)  begin n_bad++; $display("FAIL reset_release_ready got %b exp 1", ready); end
  endtask

  task automatic test_mul();
    vec_t v[$];
    vec_t t;
    logic [63:0] got, exp_v;
    int lat;
    logic rb;
    v.push_back('{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
    v.push_back('{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE});
    v.push_back('{3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{3'd1, 1'b0, '1, '1, 64'd0});
    v.push_back('{3'd0, 1'b1, 64'hDEAD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE});
    for (int i = 0; i < 4; i++) begin
      t.f3 = (i == 3) ? 3'd0 : 3'(i); t.w = (i == 3);
      t.a = {$urandom, $urandom}; t.b = {$urandom, $urandom};
      t.e = model(t.f3, t.w, t.a, t.b);
      v.push_back(t);
    end
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i]);
      wait_result(got, lat, rb);
      exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
      n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL mul_result[%0d] got %h exp %h", i, got, exp_v); end
      n_cmp++; if (lat != lat_of(v[i])) begin n_bad++; $display("FAIL mul_latency[%0d] got %0d exp %0d", i, lat, lat_of(v[i])); end
      n_cmp++; if (rb) begin n_bad++; $display("FAIL mul_ready_busy[%0d] got 1 exp 0", i); end
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mul_ready_after[%0d] got %b exp 1", i, ready); end
    end
  endtask

  task automatic test_div();
    vec_t v[$];
    vec_t t;
    logic [63:0] got, exp_v;
    int lat;
    logic rb;
    v.push_back('{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});
    v.push_back('{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{3'd5, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000});
    v.push_back('{3'd7, 1'b0, 64'd100, 64'd7, 64'd2});
    for (int i = 0; i < 4; i++) begin
      t.f3 = 3'(4 + i); t.w = i[0];
      t.a = {$urandom, $urandom}; t.b = {32'd0, $urandom} | 64'd1;
      t.e = model(t.f3, t.w, t.a, t.b);
      v.push_back(t);
    end
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i]);
      wait_result(got, lat, rb);
      exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
      n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL div_result[%0d] got %h exp %h", i, got, exp_v); end
      n_cmp++; if (lat != lat_of(v[i])) begin n_bad++; $display("FAIL div_latency[%0d] got %0d exp %0d", i, lat, lat_of(v[i])); end
      n_cmp++; if (rb) begin n_bad++; $display("FAIL div_ready_busy[%0d] got 1 exp 0", i); end
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL div_ready_after[%0d] got %b exp 1", i, ready); end
    end
  endtask

  task automatic test_special();
    vec_t v[$];
    logic [63:0] got, exp_v;
    int lat;
    logic rb;
    v.push_back('{3'd4, 1'b0, 64'd5, 64'd0, '1});
    v.push_back('{3'd6, 1'b0, 64'd5, 64'd0, 64'd5});
    v.push_back('{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000});
    v.push_back('{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0});
    v.push_back('{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000});
    v.push_back('{3'd7, 1'b1, 64'h0000_0000_9000_0000, 64'h1234_5678_0000_0000, 64'hFFFF_FFFF_9000_0000});
    v.push_back('{3'd5, 1'b0, 64'd42, 64'd0, '1});
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i]);
      wait_result(got, lat, rb);
      exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
      n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL special_result[%0d] got %h exp %h", i, got, exp_v); end
      n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL special_latency[%0d] got %0d exp 1", i, lat); end
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL special_ready_after[%0d] got %b exp 1", i, ready); end
    end
  endtask

  task automatic test_flush();
    vec_t d, m;
    logic [63:0] prev, got, exp_v;
    int lat;
    logic rb, seen;
    d = '{3'd4, 1'b0, 64'd1000, 64'd7, 64'd142};
    m = '{3'd0, 1'b0, 64'd123456, 64'd789, 64'd97406784};
    @(negedge clk);
    prev = result;
    for (int pass = 0; pass < 2; pass++) begin
      issue(d);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      void'(sb_q.pop_front());
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready_c11[%0d] got %b exp 1", pass, ready); end
      if (pass == 0) begin
        seen = 1'b0;
        for (int n = 0; n < 70; n++) begin
          if (rvalid === 1'b1) seen = 1'b1;
          @(negedge clk);
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL flush_no_rvalid got 1 exp 0"); end
        n_cmp++; if (result !== prev) begin n_bad++; $display("FAIL flush_result_held got %h exp %h", result, prev); end
      end else begin
        valid = 1'b1; funct3 = m.f3; is_op32 = m.w; op1 = m.a; op2 = m.b;
        sb_q.push_back(m.e);
        @(posedge clk);
        #1 valid = 1'b0;
        wait_result(got, lat, rb);
        exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
        n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL flush_next_mul got %h exp %h", got, exp_v); end
        n_cmp++; if (lat != lat_of(m)) begin n_bad++; $display("FAIL flush_next_latency got %0d exp %0d", lat, lat_of(m)); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t m;
    logic seen;
    m = '{3'd0, 1'b0, 64'd123, 64'd456, 64'd56088};
    issue(m);
    repeat (19) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    void'(sb_q.pop_front());
    n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_rvalid got %b exp 0", rvalid); end
    n_cmp++; if (result !== 64'd0) begin n_bad++; $display("FAIL rstmid_result got %h exp 0", result); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready_low got %b exp 0", ready); end
    rst = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (rvalid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL rstmid_no_rvalid got 1 exp 0"); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready_after got %b exp 1", ready); end
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; flush = 1'b0; is_op32 = 1'b0;
    funct3 = 3'd0; op1 = '0; op2 = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
